// File: rtl/demod_step_gen.sv
// rtl/demod_step_gen.sv - square-wave demodulator integrating high-minus-low error into a step word
module demod_step_gen #(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [ADC_BIT-1:0] i_adc,
  input  logic                      i_status,
  input  logic                      i_trig,
  input  logic [15:0]               i_wait_cnt,
  input  logic [3:0]                i_avg_sel,
  input  logic [4:0]                i_gain_sel,
  input  logic                      i_polarity,
  input  logic                      i_fb_on,
  output logic signed [ACC_BIT-1:0] o_err,
  output logic signed [ACC_BIT-1:0] o_step,
  output logic                      o_step_vld,
  output logic                      o_miss
);

  localparam int SUM_W = ADC_BIT + 15;
  localparam int DIF_W = SUM_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACC, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     status_q, status_qq, status_edge;
  logic [15:0]              wait_cnt, wait_cnt_nxt;
  logic [16:0]              smp_cnt, smp_cnt_nxt;
  logic [3:0]               avg_q, avg_q_nxt;
  logic                     half_q, half_nxt;
  logic signed [SUM_W-1:0]  acc, acc_nxt, adc_ext;
  logic signed [SUM_W-1:0]  sum_h, sum_l;
  logic                     vld_h, vld_l, latch_h, latch_l;

  logic signed [DIF_W-1:0]   diff, diff_sh;
  logic signed [ACC_BIT-1:0] e_raw, e_val, e_gain, step_sat;
  logic signed [ACC_BIT:0]   step_sum;

  assign status_edge = status_q ^ status_qq;
  assign adc_ext     = SUM_W'(i_adc);

  // An edge restarts acquisition from any state; a partial sum is simply abandoned.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    smp_cnt_nxt  = smp_cnt;
    avg_q_nxt    = avg_q;
    half_nxt     = half_q;
    acc_nxt      = acc;
    latch_h      = 1'b0;
    latch_l      = 1'b0;
    if (status_edge) begin
      half_nxt  = status_q;
      avg_q_nxt = i_avg_sel;
      if (i_wait_cnt == 16'd0) begin
        state_nxt   = ACC;
        acc_nxt     = '0;
        smp_cnt_nxt = 17'd1 << i_avg_sel;
      end else begin
        state_nxt    = WAIT;
        wait_cnt_nxt = i_wait_cnt;
      end
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt == 16'd1) begin
            state_nxt   = ACC;
            acc_nxt     = '0;
            smp_cnt_nxt = 17'd1 << avg_q;
          end else begin
            wait_cnt_nxt = wait_cnt - 16'd1;
          end
        end
        ACC: begin
          acc_nxt     = acc + adc_ext;
          smp_cnt_nxt = smp_cnt - 17'd1;
          if (smp_cnt == 17'd1) begin
            state_nxt = DONE;
            latch_h   = half_q;
            latch_l   = ~half_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    diff     = DIF_W'(sum_h) - DIF_W'(sum_l);
    diff_sh  = diff >>> avg_q;
    e_raw    = ACC_BIT'(diff_sh);
    e_val    = i_polarity ? -e_raw : e_raw;
    e_gain   = e_val >>> i_gain_sel;
    step_sum = (ACC_BIT+1)'(o_step) + (ACC_BIT+1)'(e_gain);
    step_sat = step_sum[ACC_BIT-1:0];
    // Sign bit disagreeing with the carry means the add overflowed.
    if (step_sum[ACC_BIT] != step_sum[ACC_BIT-1])
      step_sat = step_sum[ACC_BIT] ? {1'b1, {(ACC_BIT-1){1'b0}}} : {1'b0, {(ACC_BIT-1){1'b1}}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      status_q   <= 1'b0;
      status_qq  <= 1'b0;
      wait_cnt   <= '0;
      smp_cnt    <= '0;
      avg_q      <= '0;
      half_q     <= 1'b0;
      acc        <= '0;
      sum_h      <= '0;
      sum_l      <= '0;
      vld_h      <= 1'b0;
      vld_l      <= 1'b0;
      o_err      <= '0;
      o_step     <= '0;
      o_step_vld <= 1'b0;
      o_miss     <= 1'b0;
    end else begin
      state     <= state_nxt;
      status_q  <= i_status;
      status_qq <= status_q;
      wait_cnt  <= wait_cnt_nxt;
      smp_cnt   <= smp_cnt_nxt;
      avg_q     <= avg_q_nxt;
      half_q    <= half_nxt;
      acc       <= acc_nxt;
      if (latch_h) sum_h <= acc_nxt;
      if (latch_l) sum_l <= acc_nxt;
      // A half finishing on the trig cycle survives the clear and belongs to the next period.
      vld_h <= latch_h | (vld_h & ~i_trig);
      vld_l <= latch_l | (vld_l & ~i_trig);

      o_step_vld <= i_trig;
      o_miss     <= i_trig & ~(vld_h & vld_l);
      if (i_trig) begin
        if (vld_h && vld_l) begin
          o_err  <= e_val;
          o_step <= i_fb_on ? step_sat : '0;
        end else if (!i_fb_on) begin
          o_step <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_demod_step_gen.sv
// tb/tb_demod_step_gen.sv - scoreboard bench for demod_step_gen
module tb_demod_step_gen;
  localparam int ADC_BIT = 28;
  localparam int ACC_BIT = 32;
  localparam longint SMAX = (longint'(1) <<< 31) - 1;
  localparam longint SMIN = -(longint'(1) <<< 31);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic signed [ADC_BIT-1:0] adc;
  logic                      status, trig, polarity, fb_on;
  logic [15:0]               wait_cnt;
  logic [3:0]                avg_sel;
  logic [4:0]                gain_sel;
  logic signed [ACC_BIT-1:0] o_err, o_step;
  logic                      o_step_vld, o_miss;

  typedef struct {
    longint err;
    longint step;
    logic   miss;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  longint m_err  = 0;
  longint m_step = 0;

  demod_step_gen #(.ADC_BIT(ADC_BIT), .ACC_BIT(ACC_BIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_adc(adc), .i_status(status), .i_trig(trig),
    .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel), .i_gain_sel(gain_sel),
    .i_polarity(polarity), .i_fb_on(fb_on),
    .o_err(o_err), .o_step(o_step), .o_step_vld(o_step_vld), .o_miss(o_miss)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && o_step_vld) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got o_step_vld=1 expected no output");
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("o_err", longint'(o_err), x.err);
        check("o_step", longint'(o_step), x.step);
        check("o_miss", longint'(o_miss), longint'(x.miss));
      end
    end
  end

  task automatic issue_trig(input bit valid, input longint e);
    exp_t x;
    if (valid) begin
      m_err  = e;
      m_step = fb_on ? sat(m_step + (e >>> gain_sel)) : 0;
    end else if (!fb_on) begin
      m_step = 0;
    end
    x.err = m_err; x.step = m_step; x.miss = !valid;
    sb_q.push_back(x);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // One modulation period of constant-level halves; trig lands in the last low-half cycle.
  task automatic run_period(input longint hi, input longint lo, input int half_len, input bit valid);
    longint e;
    e = polarity ? -(hi - lo) : (hi - lo);
    status = 1'b1; adc = ADC_BIT'(hi);
    repeat (half_len) @(negedge clk);
    status = 1'b0; adc = ADC_BIT'(lo);
    repeat (half_len - 1) @(negedge clk);
    issue_trig(valid, e);
  endtask

  task automatic set_cfg(input int w, input int a, input int g, input bit pol, input bit fb);
    wait_cnt = 16'(w); avg_sel = 4'(a); gain_sel = 5'(g); polarity = pol; fb_on = fb;
  endtask

  initial begin
    rst_n = 1'b0; status = 1'b0; trig = 1'b0; adc = '0;
    set_cfg(10, 6, 4, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_o_err", longint'(o_err), 0);
    check("rst_o_step", longint'(o_step), 0);
    check("rst_o_step_vld", longint'(o_step_vld), 0);
    check("rst_o_miss", longint'(o_miss), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal loop: err 1000, step +62 per period
    repeat (3) run_period(500, -500, 100, 1'b1);

    // Inverted polarity: err -1000, step -63 per period
    polarity = 1'b1;
    repeat (3) run_period(500, -500, 100, 1'b1);

    // Settling + averaging longer than a half: every trig is a miss
    set_cfg(60, 6, 4, 1'b0, 1'b1);
    repeat (2) run_period(500, -500, 100, 1'b0);

    // Back-to-back trig: second one sees cleared flags
    set_cfg(10, 6, 4, 1'b0, 1'b1);
    run_period(300, -200, 100, 1'b1);
    issue_trig(1'b0, 0);

    // Feedback off forces step to 0 at trig; on again resumes from 0
    fb_on = 1'b0;
    repeat (2) run_period(500, -500, 100, 1'b1);
    fb_on = 1'b1;
    repeat (2) run_period(500, -500, 100, 1'b1);

    // Positive then negative saturation with a large error and unity gain
    set_cfg(0, 0, 0, 1'b0, 1'b1);
    repeat (10) run_period(134217727, -134217728, 8, 1'b1);
    @(negedge clk);
    check("sat_pos", longint'(o_step), SMAX);
    polarity = 1'b1;
    repeat (18) run_period(134217727, -134217728, 8, 1'b1);
    @(negedge clk);
    check("sat_neg", longint'(o_step), SMIN);

    // Reset in the middle of accumulation
    set_cfg(10, 6, 4, 1'b0, 1'b1);
    status = 1'b1; adc = ADC_BIT'(500);
    repeat (40) @(negedge clk);
    rst_n = 1'b0; status = 1'b0;
    m_err = 0; m_step = 0;
    repeat (3) @(negedge clk);
    check("midrst_o_err", longint'(o_err), 0);
    check("midrst_o_step", longint'(o_step), 0);
    check("midrst_o_step_vld", longint'(o_step_vld), 0);
    check("midrst_o_miss", longint'(o_miss), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue_trig(1'b0, 0);
    run_period(500, -500, 100, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
